// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with valid/ready handshake and multi-cycle MUL/DIV occupancy tracking.
// Latency 1 cycle to out_valid. stall = !in_ready. Optional DIV decode under `ifdef ALU_DIV_EN.
module alu_ctrl_seq #(
  parameter int OPCODE_W    = 6,
  parameter int CTRL_W      = 2,
  parameter int MUL_LATENCY = 3,
  parameter int DIV_LATENCY = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CTRL_W-1:0]   alu_ctrl,
  output logic                illegal,
  output logic                stall
);

  typedef enum logic [1:0] {IDLE, OUT, MULTI} state_t;

  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(6'b000001);
  localparam logic [OPCODE_W-1:0] OP_MUL = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_DIV = OPCODE_W'(6'b000011);
  localparam logic [OPCODE_W-1:0] OP_LDB = OPCODE_W'(6'b010000);
  localparam logic [OPCODE_W-1:0] OP_LDW = OPCODE_W'(6'b010001);
  localparam logic [OPCODE_W-1:0] OP_STB = OPCODE_W'(6'b010010);
  localparam logic [OPCODE_W-1:0] OP_STW = OPCODE_W'(6'b010011);
  localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(6'b110000);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LATENCY - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LATENCY - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              illegal_q, illegal_d;

  logic [1:0]        dec_ctrl;
  logic              dec_illegal;
  logic [3:0]        dec_cnt;
  logic              accept;

  always_comb begin
    dec_ctrl    = 2'b00;
    dec_illegal = 1'b0;
    dec_cnt     = 4'd0;
    case (opcode)
      OP_ADD, OP_LDB, OP_LDW, OP_STB, OP_STW: dec_ctrl = 2'b00;
      OP_SUB, OP_BEQ:                         dec_ctrl = 2'b10;
      OP_MUL: begin
        dec_ctrl = 2'b01;
        dec_cnt  = MUL_CNT;
      end
`ifdef ALU_DIV_EN
      OP_DIV: begin
        dec_ctrl = 2'b11;
        dec_cnt  = DIV_CNT;
      end
`endif
      default: dec_illegal = 1'b1;
    endcase
  end

`ifndef ALU_DIV_EN
  // DIV decode is compiled out; keep the latency parameter referenced.
  logic div_cnt_unused;
  assign div_cnt_unused = ^{DIV_CNT, OP_DIV};
`endif

  // Flush masks readiness so a coincident opcode is never accepted.
  always_comb begin
    in_ready = 1'b0;
    if (!flush) begin
      case (state_q)
        IDLE:    in_ready = 1'b1;
        OUT:     in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept    = in_valid && in_ready;
  assign stall     = !in_ready;
  assign out_valid = (state_q != IDLE);
  assign alu_ctrl  = ctrl_q;
  assign illegal   = illegal_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;
    if (flush) begin
      state_d   = IDLE;
      cnt_d     = 4'd0;
      ctrl_d    = '0;
      illegal_d = 1'b0;
    end else if (accept) begin
      state_d   = (dec_cnt != 4'd0) ? MULTI : OUT;
      cnt_d     = dec_cnt;
      ctrl_d    = CTRL_W'(dec_ctrl);
      illegal_d = dec_illegal;
    end else begin
      case (state_q)
        OUT: begin
          if (out_ready) state_d = IDLE;
        end
        MULTI: begin
          cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
          if (cnt_q <= 4'd1) state_d = OUT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
